mux_rr_selector: RTL

MUX_RR_SELECTOR -- requirements
Module: mux_rr_selector

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/mux_rr_selector.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and sizing for the round-robin channel selector.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Channel index reached by stepping 'step' places past 'base', wrapping mod NUM_CH.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base,
                                                input int unsigned      step);
        return base + SEL_W'(step);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search: first requesting channel after 'last', wrapping.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic              any,
    output logic [SEL_W-1:0]  winner
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_winner;

    // Search starts at last+1 so the previous owner is considered last.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = last;
        w_winner = last;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = rr_idx(last, k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign any    = w_found;
    assign winner = w_winner;

endmodule

// File: rtl/mux_rr_selector.sv
// Round-robin 4:1 channel selector: grants a channel, dwells DWELL cycles on it,
// samples its data bit and holds the sample until the downstream accepts it.
module mux_rr_selector
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] datain,
    input  logic              ready,
    output logic [SEL_W-1:0]  select,
    output logic              sel_valid,
    output logic              outd_q,
    output logic              busy
);

    generate
        if (DWELL < 1 || DWELL > 16) begin : g_bad_dwell
            $error("mux_rr_selector: DWELL must be in 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_select;
    logic [SEL_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel_valid;
    logic             r_outd;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [SEL_W-1:0] w_pick_last;
    logic             w_any;
    logic [SEL_W-1:0] w_winner;
    logic             w_req_sel;
    logic             w_load_grant;
    logic             w_cnt_dec;
    logic             w_sample;
    logic             w_release;

    // On release the finishing channel becomes lowest priority in the same-cycle re-arbitration.
    assign w_pick_last = (r_state == HOLD) ? r_select : r_last_grant;
    assign w_req_sel   = req[r_select];

    rr_pick4 u_pick (
        .req    (req),
        .last   (w_pick_last),
        .any    (w_any),
        .winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!w_req_sel) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    w_state_nxt = w_any ? GRANT : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load_grant = 1'b0;
        w_cnt_dec    = 1'b0;
        w_sample     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_grant = w_any;
            end
            GRANT: begin
                w_cnt_dec = w_req_sel && (r_cnt != '0);
                w_sample  = w_req_sel && (r_cnt == '0);
            end
            HOLD: begin
                w_release    = ready;
                w_load_grant = ready && w_any;
            end
            default: begin
                w_load_grant = 1'b0;
            end
        endcase
    end

    // A withdrawn request leaves last_grant untouched; only a completed handshake rotates priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_select     <= '0;
            r_last_grant <= 2'b11;
            r_cnt        <= '0;
            r_sel_valid  <= 1'b0;
            r_outd       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            if (w_load_grant) begin
                r_select <= w_winner;
                r_cnt    <= CNT_INIT;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_release) begin
                r_last_grant <= r_select;
            end
            if (w_sample) begin
                r_outd      <= datain[r_select];
                r_sel_valid <= 1'b1;
            end else if (w_release) begin
                r_sel_valid <= 1'b0;
            end
        end
    end

    assign select    = r_select;
    assign sel_valid = r_sel_valid;
    assign outd_q    = r_outd;
    assign busy      = r_busy;

endmodule
